line_commit_scheduler: RTL and testbench
========================================

// Module: line_commit_scheduler
// PURPOSE
//  Sequences commits of completed PPU scanlines into the four 160-bit video line RAMs read by the VGA scan-out.
//  Detects new-line requests from the PPU and queues their line numbers (LY) in a small FIFO.
//  The external slot holding registers are indexed by pushSlot/popSlot.
//  Each queued line is written to the RAMs only while the scan-out is outside the active read region, so a read and a write never collide.
// PARAMETERS
//  DEPTH     4    pending-line FIFO depth; must be a power of 2
//  PTR_W     2    log2(DEPTH)
//  H_ACTIVE  160  first HCount value outside the read region
//  H_TOTAL   800  pixel clocks per line; HCount wraps at H_TOTAL-1
//  V_ACTIVE  144  first VCount value outside the read region
//  V_TOTAL   525  lines per frame
// PORTS
//  pixelClk            in   1      pixel clock; all logic on its rising edge
//  nReset              in   1      asynchronous, active-low reset
//  LY                  in   8      PPU current line number
//  updateBufferSignal  in   1      PPU: line buffers valid for LY
//  HCount              in   10     scan-out horizontal counter
//  VCount              in   10     scan-out vertical counter
//  latchLine           out  1      1-cycle pulse: capture LineBuffer0..3 into holding slot pushSlot
//  pushSlot            out  PTR_W  holding slot written on latchLine
//  popSlot             out  PTR_W  holding slot selected as RAM write data
//  wrAddr              out  8      RAM write address; the LY of the head entry
//  wr_buffer           out  1      RAM write enable; exactly 1 cycle per commit
//  pending             out  PTR_W+1  number of queued lines, 0..DEPTH
//  overflow            out  1      sticky: a request was dropped because the FIFO was full
//  clearOverflow       in   1      synchronous clear of overflow
// BEHAVIOUR
//  Reset: every output is 0 and FIFO pointers are 0. lastLY=8'hFF. State is IDLE.
//   Reset mid-commit drops wr_buffer immediately (asynchronous) and discards all entries.
//  Request: req = updateBufferSignal && (LY != lastLY), sampled each cycle.
//   On req, lastLY<=LY whether or not the request is accepted.
//  Push: on req with FIFO not full, or full with a pop in the same cycle:
//   - store LY at the write pointer
//   - pulse latchLine in that cycle, with pushSlot = write pointer
//   - advance the write pointer, modulo DEPTH
//  Drop: on req with FIFO full and no pop, the request is not stored and latchLine stays 0.
//   overflow<=1 next cycle. If clearOverflow and a drop occur in the same cycle, the set wins.
//  Window: win = (HCount>=H_ACTIVE && HCount<=H_TOTAL-4) || (VCount>=V_ACTIVE && VCount<=V_TOTAL-2)
//   || (VCount==V_TOTAL-1 && HCount<=H_TOTAL-4).
//   This guarantees 3 cycles before the read region resumes.
//  FSM, one transition per clock:
//   IDLE  : pending!=0 && win -> SETUP; otherwise stay.
//   SETUP : wrAddr<=head LY and popSlot<=read pointer, held from here through HOLD -> WRITE
//   WRITE : wr_buffer=1 for this cycle only -> HOLD
//   HOLD  : wr_buffer=0. Pop: the read pointer advances modulo DEPTH -> IDLE
//  Commit latency: 3 cycles, from leaving IDLE to the pop. Minimum spacing between two commits is 4 cycles.
//  A push and a pop in the same cycle leave pending unchanged. pending is never above DEPTH and never wraps below 0.
//  Commits happen in strict FIFO order. LY values that repeat non-consecutively are re-queued; only consecutive duplicates are filtered.
//  The FSM ignores win after IDLE. The window check is guaranteed 3 cycles of margin.
// TESTING
//  1. Reset, then LY=5 with updateBufferSignal=1 held 10 cycles.
//     -> exactly one latchLine with pushSlot=0, and pending=1.
//  2. A queued line and HCount=100, VCount=10.
//     -> no wr_buffer until HCount=160. Then SETUP at 160, wr_buffer=1 at the cycle HCount=162 with wrAddr=5, pending=0 after HCount=163.
//  3. Five distinct LY requests (1..5), back to back, with win=0.
//     -> pending=4, overflow=1. Then open the window: commits in order wrAddr=1,2,3,4 with popSlot=0,1,2,3.
//  4. HCount=797 with a queued line.
//     -> no commit starts. Check VCount=524/HCount=796 -> commit starts, and wr_buffer is done before HCount wraps to 0.
//  5. FIFO full, and a new request in the HOLD cycle of a commit.
//     -> the request is accepted, pending stays 4, and overflow is not set.
//  6. nReset low during WRITE.
//     -> wr_buffer=0 immediately. After release: pending=0, and LY=5 is accepted again because lastLY=8'hFF.

Source files
------------

// File: rtl/line_commit_scheduler.sv
// Queues completed PPU scanlines and commits each one to the video line RAMs
// only while the VGA scan-out is outside its active read region.
module line_commit_scheduler #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 144,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic             pixelClk,
  input  logic             nReset,
  input  logic [7:0]       LY,
  input  logic             updateBufferSignal,
  input  logic [9:0]       HCount,
  input  logic [9:0]       VCount,
  output logic             latchLine,
  output logic [PTR_W-1:0] pushSlot,
  output logic [PTR_W-1:0] popSlot,
  output logic [7:0]       wrAddr,
  output logic             wr_buffer,
  output logic [PTR_W:0]   pending,
  output logic             overflow,
  input  logic             clearOverflow
);

  localparam logic [9:0]   HActive   = 10'(H_ACTIVE);
  localparam logic [9:0]   HLast     = 10'(H_TOTAL - 4);
  localparam logic [9:0]   VActive   = 10'(V_ACTIVE);
  localparam logic [9:0]   VLast     = 10'(V_TOTAL - 2);
  localparam logic [9:0]   VEnd      = 10'(V_TOTAL - 1);
  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StSetup, StWrite, StHold} stateT;

  stateT            state;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [7:0]       lastLY;
  logic [7:0]       lyMem [DEPTH];

  logic req, full, pop, push, drop, win;

  always_comb begin
    req  = updateBufferSignal && (LY != lastLY);
    full = (pending == FullCount);
    pop  = (state == StHold);
    // A pop in the same cycle frees the slot the new request needs.
    push = req && (!full || pop);
    drop = req && full && !pop;
    // The last 3 pixels before the read region resumes are excluded so a commit
    // started here always finishes outside it.
    win  = (HCount >= HActive && HCount <= HLast) ||
           (VCount >= VActive && VCount <= VLast) ||
           (VCount == VEnd && HCount <= HLast);
    latchLine = push;
    pushSlot  = wrPtr;
  end

  always_ff @(posedge pixelClk) begin
    if (push) lyMem[wrPtr] <= LY;
  end

  always_ff @(posedge pixelClk or negedge nReset) begin
    if (!nReset) begin
      state     <= StIdle;
      wrPtr     <= '0;
      rdPtr     <= '0;
      lastLY    <= 8'hFF;
      pending   <= '0;
      overflow  <= 1'b0;
      wrAddr    <= '0;
      popSlot   <= '0;
      wr_buffer <= 1'b0;
    end else begin
      if (req)  lastLY <= LY;
      if (push) wrPtr  <= wrPtr + 1'b1;
      if (pop)  rdPtr  <= rdPtr + 1'b1;

      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase

      if (drop)               overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;

      case (state)
        StIdle: begin
          if (pending != '0 && win) begin
            state   <= StSetup;
            wrAddr  <= lyMem[rdPtr];
            popSlot <= rdPtr;
          end
        end
        StSetup: begin
          state     <= StWrite;
          wr_buffer <= 1'b1;
        end
        StWrite: begin
          state     <= StHold;
          wr_buffer <= 1'b0;
        end
        StHold: begin
          state <= StIdle;
        end
        default: begin
          state     <= StIdle;
          wr_buffer <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_commit_scheduler.sv
// Directed bench for line_commit_scheduler: queueing, window gating, FIFO order,
// overflow, push-on-pop when full, and asynchronous reset mid-commit.
module tb_line_commit_scheduler;

  logic       pixelClk = 1'b0;
  logic       nReset;
  logic [7:0] LY;
  logic       updateBufferSignal;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       latchLine;
  logic [1:0] pushSlot;
  logic [1:0] popSlot;
  logic [7:0] wrAddr;
  logic       wr_buffer;
  logic [2:0] pending;
  logic       overflow;
  logic       clearOverflow;

  int   total = 0;
  int   bad   = 0;
  logic scanRun = 1'b0;

  line_commit_scheduler dut (
    .pixelClk           (pixelClk),
    .nReset             (nReset),
    .LY                 (LY),
    .updateBufferSignal (updateBufferSignal),
    .HCount             (HCount),
    .VCount             (VCount),
    .latchLine          (latchLine),
    .pushSlot           (pushSlot),
    .popSlot            (popSlot),
    .wrAddr             (wrAddr),
    .wr_buffer          (wr_buffer),
    .pending            (pending),
    .overflow           (overflow),
    .clearOverflow      (clearOverflow)
  );

  always #5 pixelClk = ~pixelClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the scan counters advance just after the edge when running.
  task automatic tick();
    @(posedge pixelClk);
    #1;
    if (scanRun) begin
      if (HCount == 10'd799) begin
        HCount = 10'd0;
        VCount = (VCount == 10'd524) ? 10'd0 : VCount + 10'd1;
      end else begin
        HCount = HCount + 10'd1;
      end
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         latchCount;
    logic [1:0] firstSlot;
    logic       earlyWr;
    logic       anyWr;
    int         n;
    logic [7:0] gotAddr [4];
    logic [1:0] gotSlot [4];

    // Test 1: reset values, then one request held for 10 cycles.
    nReset = 1'b0;
    LY = 8'd0;
    updateBufferSignal = 1'b0;
    HCount = 10'd100;
    VCount = 10'd10;
    clearOverflow = 1'b0;
    #12;
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_buffer", wr_buffer, 0);
    check("rst_latchLine", latchLine, 0);
    check("rst_wrAddr", wrAddr, 0);
    check("rst_popSlot", popSlot, 0);
    check("rst_pushSlot", pushSlot, 0);
    nReset = 1'b1;
    tick();
    LY = 8'd5;
    updateBufferSignal = 1'b1;
    latchCount = 0;
    firstSlot = 2'd3;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (latchLine) begin
        latchCount++;
        firstSlot = pushSlot;
      end
      tick();
    end
    updateBufferSignal = 1'b0;
    check("t1_latch_count", latchCount, 1);
    check("t1_push_slot", firstSlot, 0);
    check("t1_pending", pending, 1);

    // Test 2: commit waits for HCount=160, writes at 162, pops after 163.
    scanRun = 1'b1;
    earlyWr = 1'b0;
    while (HCount < 10'd160) begin
      if (wr_buffer) earlyWr = 1'b1;
      tick();
    end
    check("t2_no_early_wr", earlyWr, 0);
    check("t2_idle_at_160", wr_buffer, 0);
    tick();
    check("t2_setup_wr", wr_buffer, 0);
    tick();
    check("t2_write", wr_buffer, 1);
    check("t2_wrAddr", wrAddr, 5);
    check("t2_popSlot", popSlot, 0);
    check("t2_pending_write", pending, 1);
    tick();
    check("t2_hold_wr", wr_buffer, 0);
    tick();
    check("t2_pending_after", pending, 0);
    scanRun = 1'b0;

    // Test 3: five requests against a closed window, then drain in order.
    nReset = 1'b0;
    #1;
    nReset = 1'b1;
    HCount = 10'd100;
    VCount = 10'd10;
    for (int i = 1; i <= 5; i++) begin
      LY = 8'(i);
      updateBufferSignal = 1'b1;
      #1;
      check("t3_latch", latchLine, (i <= 4) ? 1 : 0);
      if (i <= 4) check("t3_push_slot", pushSlot, i - 1);
      tick();
    end
    updateBufferSignal = 1'b0;
    check("t3_pending_full", pending, 4);
    check("t3_overflow", overflow, 1);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("t3_overflow_clear", overflow, 0);
    HCount = 10'd200;
    n = 0;
    for (int c = 0; c < 24; c++) begin
      if (wr_buffer) begin
        if (n < 4) begin
          gotAddr[n] = wrAddr;
          gotSlot[n] = popSlot;
        end
        n++;
      end
      tick();
    end
    HCount = 10'd100;
    check("t3_commit_count", n, 4);
    for (int k = 0; k < 4; k++) begin
      check("t3_order_addr", gotAddr[k], k + 1);
      check("t3_order_slot", gotSlot[k], k);
    end
    check("t3_pending_drained", pending, 0);

    // Test 4: no start at HCount=797; start at 524/796 finishes before the wrap.
    HCount = 10'd797;
    VCount = 10'd10;
    LY = 8'd9;
    updateBufferSignal = 1'b1;
    tick();
    updateBufferSignal = 1'b0;
    check("t4_pending", pending, 1);
    anyWr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (wr_buffer) anyWr = 1'b1;
      tick();
    end
    check("t4_no_commit_797", anyWr, 0);
    check("t4_pending_held", pending, 1);
    VCount = 10'd524;
    HCount = 10'd796;
    scanRun = 1'b1;
    tick();
    check("t4_setup", wr_buffer, 0);
    tick();
    check("t4_write", wr_buffer, 1);
    check("t4_wrAddr", wrAddr, 9);
    tick();
    check("t4_done_at_799", wr_buffer, 0);
    tick();
    check("t4_pending_after", pending, 0);
    scanRun = 1'b0;

    // Test 5: full FIFO, new request during HOLD is accepted.
    HCount = 10'd100;
    VCount = 10'd10;
    for (int i = 0; i < 4; i++) begin
      LY = 8'(20 + i);
      updateBufferSignal = 1'b1;
      tick();
    end
    updateBufferSignal = 1'b0;
    check("t5_pending_full", pending, 4);
    HCount = 10'd200;
    tick();
    HCount = 10'd100;
    tick();
    check("t5_write", wr_buffer, 1);
    check("t5_wrAddr", wrAddr, 20);
    check("t5_popSlot", popSlot, 1);
    tick();
    check("t5_hold", wr_buffer, 0);
    LY = 8'd30;
    updateBufferSignal = 1'b1;
    #1;
    check("t5_latch_in_hold", latchLine, 1);
    check("t5_push_slot", pushSlot, 1);
    tick();
    updateBufferSignal = 1'b0;
    check("t5_pending_same", pending, 4);
    check("t5_no_overflow", overflow, 0);

    // Test 6: reset during WRITE, then lastLY is forgotten.
    HCount = 10'd200;
    tick();
    HCount = 10'd100;
    tick();
    check("t6_write", wr_buffer, 1);
    check("t6_wrAddr", wrAddr, 21);
    nReset = 1'b0;
    #1;
    check("t6_async_wr", wr_buffer, 0);
    check("t6_pending", pending, 0);
    check("t6_popSlot", popSlot, 0);
    nReset = 1'b1;
    LY = 8'd30;
    updateBufferSignal = 1'b1;
    #1;
    check("t6_reaccept", latchLine, 1);
    check("t6_push_slot", pushSlot, 0);
    tick();
    #1;
    check("t6_dup_filtered", latchLine, 0);
    LY = 8'd31;
    tick();
    LY = 8'd30;
    #1;
    check("t6_requeue", latchLine, 1);
    check("t6_requeue_slot", pushSlot, 2);
    tick();
    updateBufferSignal = 1'b0;
    check("t6_pending_end", pending, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
